// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 streaming convolution datapath.
// Default kernel is Sobel-X; element i sits at bits [i*COEF_W +: COEF_W].
package conv_pkg;
    localparam int TAPS   = 9;
    localparam int DATA_W = 32;
    localparam int COEF_W = 8;
    localparam int ACC_W  = 44;
    localparam int CNT_W  = $clog2(TAPS + 1);

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    localparam sample_t SAT_MAX = 32'h7FFF_FFFF;
    localparam sample_t SAT_MIN = 32'h8000_0000;

    // Packed tap-8 first: {-1, 0, 1, -2, 0, 2, -1, 0, 1}
    localparam logic [TAPS*COEF_W-1:0] KERNEL_SOBEL_X = {
        8'hFF, 8'h00, 8'h01,
        8'hFE, 8'h00, 8'h02,
        8'hFF, 8'h00, 8'h01
    };
endpackage

// File: rtl/conv_mac9.sv
// Combinational 9-tap signed multiply-accumulate with saturation to DATA_W.
// Zero latency; no flow control (pure function of window and kernel).
module conv_mac9 #(
    parameter int DATA_W = conv_pkg::DATA_W,
    parameter int COEF_W = conv_pkg::COEF_W
) (
    input  logic [conv_pkg::TAPS-1:0][DATA_W-1:0] win,
    input  logic [conv_pkg::TAPS*COEF_W-1:0]      kernel,
    output logic [DATA_W-1:0]                     result
);
    import conv_pkg::*;

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + 4;

    // Saturation bounds expressed at accumulator width
    localparam logic signed [SUM_W-1:0] HI = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] LO = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  acc;

    always_comb begin
        prod = '0;
        acc  = '0;
        for (int i = 0; i < TAPS; i++) begin
            prod = $signed(win[i]) * $signed(kernel[i*COEF_W +: COEF_W]);
            acc  = acc + SUM_W'(prod);
        end
    end

    always_comb begin
        if (acc > HI)
            result = HI[DATA_W-1:0];
        else if (acc < LO)
            result = LO[DATA_W-1:0];
        else
            result = acc[DATA_W-1:0];
    end
endmodule

// File: rtl/convolution_layer_core.sv
// Streaming 3x3 convolution: 9-tap sliding window times fixed kernel, saturated.
// One-cycle latency from the filling sample; no backpressure, one result per accepted sample once full.
module convolution_layer_core #(
    parameter int                                  DATA_W = conv_pkg::DATA_W,
    parameter int                                  COEF_W = conv_pkg::COEF_W,
    parameter logic [conv_pkg::TAPS*COEF_W-1:0]    KERNEL = conv_pkg::KERNEL_SOBEL_X
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic [DATA_W-1:0] conv_out,
    output logic              conv_valid
);
    import conv_pkg::*;

    logic [TAPS-1:0][DATA_W-1:0] taps;
    logic [TAPS-1:0][DATA_W-1:0] next_win;
    logic [CNT_W-1:0]            count;
    logic [DATA_W-1:0]           mac_result;
    logic                        full_after;

    // Tap 0 is the oldest sample; the MAC sees the window as it will be after this shift
    assign next_win   = {data_in, taps[TAPS-1:1]};
    assign full_after = (count >= CNT_W'(TAPS - 1));

    conv_mac9 #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W)
    ) u_mac (
        .win    (next_win),
        .kernel (KERNEL),
        .result (mac_result)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taps       <= '0;
            count      <= '0;
            conv_out   <= '0;
            conv_valid <= 1'b0;
        end else begin
            conv_valid <= 1'b0;
            if (valid) begin
                taps <= next_win;
                if (count != CNT_W'(TAPS))
                    count <= count + 1'b1;
                if (full_after) begin
                    conv_out   <= mac_result;
                    conv_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_convolution_layer_core.sv
// Scoreboard bench for convolution_layer_core: model pushes expected results, DUT strobes pop them.
module tb_convolution_layer_core;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        valid;
    logic [31:0] conv_out;
    logic        conv_valid;

    int total = 0;
    int bad   = 0;

    logic signed [31:0] mwin [9];
    int                 mcount;
    logic [31:0]        sb [$];
    logic [31:0]        exp_out;
    int                 kern [9] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};

    convolution_layer_core dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid      (valid),
        .conv_out   (conv_out),
        .conv_valid (conv_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sat(input longint a);
        if (a > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (a < -64'sd2147483648) return 32'h8000_0000;
        return a[31:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 9; i++) mwin[i] = '0;
        mcount  = 0;
        exp_out = '0;
        sb.delete();
    endtask

    // Drives one cycle; the model updates on the edge and pushes any expected result
    task automatic step(input logic [31:0] d, input logic v, output logic ev);
        longint acc;
        @(negedge clk);
        data_in = d;
        valid   = v;
        @(posedge clk);
        ev = 1'b0;
        if (v) begin
            for (int i = 0; i < 8; i++) mwin[i] = mwin[i+1];
            mwin[8] = d;
            if (mcount < 9) mcount++;
            if (mcount == 9) begin
                acc = 0;
                for (int i = 0; i < 9; i++) acc += longint'(mwin[i]) * kern[i];
                sb.push_back(sat(acc));
                ev = 1'b1;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        valid   = 1'b0;
        reset   = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        valid   = 1'b0;
        data_in = '0;
        model_clear();
        #3;
        total++;
        if (conv_out !== 32'h0 || conv_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: out=%h vld=%b required out=0 vld=0", conv_out, conv_valid);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_fill();
        logic ev;
        logic [31:0] e;
        for (int k = 1; k <= 9; k++) begin
            step(32'(k), 1'b1, ev);
            total++;
            if (conv_valid !== ev) begin
                bad++;
                $display("FAIL fill_vld[%0d]: got %b required %b", k, conv_valid, ev);
            end
            if (ev) begin
                e = sb.pop_front();
                exp_out = e;
                total++;
                if (conv_out !== 32'hFFFF_FFF8 || conv_out !== e) begin
                    bad++;
                    $display("FAIL fill_out: got %h required fffffff8 (model %h)", conv_out, e);
                end
            end
        end
    endtask

    task automatic test_sliding();
        logic ev;
        logic [31:0] e;
        logic [31:0] stim [12];
        stim[0] = 32'd10;
        for (int i = 1; i < 6; i++) stim[i] = '0;
        for (int i = 6; i < 12; i++) stim[i] = $urandom() >> $urandom_range(0, 20);
        for (int i = 0; i < 12; i++) begin
            step(stim[i], 1'b1, ev);
            total++;
            if (conv_valid !== 1'b1 || sb.size() == 0) begin
                bad++;
                $display("FAIL slide_vld[%0d]: got %b required 1", i, conv_valid);
            end else begin
                e = sb.pop_front();
                exp_out = e;
                total++;
                if (conv_out !== e) begin
                    bad++;
                    $display("FAIL slide_out[%0d]: got %h required %h", i, conv_out, e);
                end
                if (i == 0) begin
                    total++;
                    if (conv_out !== 32'hFFFF_FFF8) begin
                        bad++;
                        $display("FAIL slide_first: got %h required fffffff8", conv_out);
                    end
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic ev;
        logic [31:0] e;
        logic [31:0] req [2];
        req[0] = 32'h7FFF_FFFF;
        req[1] = 32'h8000_0000;
        for (int p = 0; p < 2; p++) begin
            apply_reset();
            for (int k = 0; k < 9; k++)
                step((k % 3 == 2 * p) ? 32'h7FFF_FFFF : 32'h0, 1'b1, ev);
            total++;
            if (conv_valid !== 1'b1 || sb.size() != 1) begin
                bad++;
                $display("FAIL sat_vld[%0d]: got %b required 1", p, conv_valid);
            end else begin
                e = sb.pop_front();
                exp_out = e;
                total++;
                if (conv_out !== req[p] || e !== req[p]) begin
                    bad++;
                    $display("FAIL sat_out[%0d]: got %h required %h", p, conv_out, req[p]);
                end
            end
        end
    endtask

    task automatic test_gaps();
        logic ev;
        logic [31:0] e;
        int k;
        apply_reset();
        k = 1;
        while (k <= 9) begin
            if ($urandom_range(0, 2) == 0) begin
                step($urandom(), 1'b0, ev);
                total++;
                if (conv_valid !== 1'b0 || conv_out !== exp_out) begin
                    bad++;
                    $display("FAIL gap_hold: out=%h vld=%b required out=%h vld=0", conv_out, conv_valid, exp_out);
                end
            end else begin
                step(32'(k), 1'b1, ev);
                total++;
                if (conv_valid !== ev) begin
                    bad++;
                    $display("FAIL gap_vld[%0d]: got %b required %b", k, conv_valid, ev);
                end
                if (ev) begin
                    e = sb.pop_front();
                    exp_out = e;
                    total++;
                    if (conv_out !== 32'hFFFF_FFF8) begin
                        bad++;
                        $display("FAIL gap_out: got %h required fffffff8", conv_out);
                    end
                end
                k++;
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic ev;
        logic [31:0] e;
        for (int k = 0; k < 5; k++) step(32'(100 + k), 1'b1, ev);
        sb.delete();
        reset = 1'b0;
        #1;
        total++;
        if (conv_out !== 32'h0 || conv_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: out=%h vld=%b required out=0 vld=0", conv_out, conv_valid);
        end
        model_clear();
        // Reset wins over a simultaneous valid sample
        @(negedge clk);
        data_in = 32'd77;
        valid   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        reset = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(32'(k), 1'b1, ev);
            total++;
            if (conv_valid !== ev) begin
                bad++;
                $display("FAIL mid_vld[%0d]: got %b required %b", k, conv_valid, ev);
            end
            if (ev) begin
                e = sb.pop_front();
                exp_out = e;
                total++;
                if (conv_out !== 32'hFFFF_FFF8) begin
                    bad++;
                    $display("FAIL mid_out: got %h required fffffff8", conv_out);
                end
            end
        end
    endtask

    task automatic test_idle();
        logic ev;
        int errs = 0;
        for (int c = 0; c < 20; c++) begin
            step($urandom(), 1'b0, ev);
            if (conv_valid !== 1'b0 || conv_out !== exp_out) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL idle_hold: %0d bad cycles, out=%h required %h vld=0", errs, conv_out, exp_out);
        end
    endtask

    task automatic test_back_to_back();
        logic ev;
        logic [31:0] e;
        for (int i = 0; i < 25; i++) begin
            step($urandom(), 1'b1, ev);
            total++;
            if (conv_valid !== 1'b1 || sb.size() == 0) begin
                bad++;
                $display("FAIL b2b_vld[%0d]: got %b required 1", i, conv_valid);
            end else begin
                e = sb.pop_front();
                exp_out = e;
                total++;
                if (conv_out !== e) begin
                    bad++;
                    $display("FAIL b2b_out[%0d]: got %h required %h", i, conv_out, e);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_sliding();
        test_saturation();
        test_gaps();
        test_reset_midstream();
        test_idle();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
